uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART transmitter (8N1, baud-ticked, edge-triggered load) among NUM_REQ byte requesters.
//  - Grants requesters round-robin and presents the granted byte on tx_data_in.
//  - Produces a load edge the transmitter is guaranteed to catch, then tracks busy to completion.
//  - Acknowledges each requester only when its byte has left the wire.
// PARAMETERS
//  NUM_REQ      4     number of requesters, >=2
//  ACK_TIMEOUT  2048  clk cycles in LOAD waiting for tx_busy before abort; must exceed 2*CLK_FRQ/BAUD_RATE
// PORTS
//  clk           in   1          system clock (one clock domain)
//  areset_n      in   1          reset, asynchronous and active-low
//  req_valid     in   NUM_REQ    requester i has a byte; held high, data stable, until req_ready[i]
//  req_data      in   8*NUM_REQ  byte of requester i at [8*i+7:8*i]
//  req_ready     out  NUM_REQ    one-cycle pulse: byte of requester i fully transmitted
//  tx_data_loaded out 1          load strobe to transmitter
//  tx_data_in    out  8          byte to transmitter
//  tx_busy       in   1          transmitter busy
//  tx_done       in   1          transmitter done (sticky until next load; informational only)
//  gnt_id        out  $clog2(NUM_REQ)  index of current grant; valid while busy=1
//  busy          out  1          arbiter holds a grant
//  timeout_err   out  1          one-cycle pulse: granted byte aborted, tx never went busy
// BEHAVIOUR
//  Reset (async, areset_n=0): state=IDLE, req_ready=0, tx_data_loaded=0, tx_data_in=0, gnt_id=0,
//    busy=0, timeout_err=0, timer=0, last_gnt=NUM_REQ-1 (first search starts at index 0).
//    Mid-operation reset abandons the in-flight byte; no req_ready for it.
//  FSM: IDLE -> LOAD -> WAIT_BUSY_LOW -> IDLE.
//  IDLE:
//   - If any req_valid, pick the first set index scanning last_grant+1, +2, ... modulo NUM_REQ.
//   - Register gnt_id, tx_data_in=req_data[gnt], last_gnt=gnt; busy=1; timer=0; go to LOAD.
//   - Arbitration to LOAD takes 1 cycle.
//   - If no req_valid, stay in IDLE with busy=0.
//  LOAD:
//   - tx_data_loaded toggles every clk, starting at 1 on LOAD entry.
//     The transmitter only samples load edges on its baud tick, so the edges must keep coming.
//   - tx_data_in is held constant. timer increments each cycle.
//   - On tx_busy=1: tx_data_loaded=0, go to WAIT_BUSY_LOW.
//   - Else, when timer==ACK_TIMEOUT-1: tx_data_loaded=0, timeout_err pulse, busy=0, go to IDLE.
//     req_ready stays 0, and last_gnt already points past the failed requester.
//   - If tx_busy and timeout occur in the same cycle, tx_busy wins.
//  WAIT_BUSY_LOW:
//   - Hold tx_data_in. On tx_busy falling (1 -> 0 vs registered previous value):
//     req_ready[gnt_id]=1 for 1 cycle, busy=0, go to IDLE.
//   - The next arbitration may occur in the cycle after the req_ready pulse.
//   - Requester i sampling req_ready[i]=1 may drop or change valid/data the next cycle.
//  Rules:
//   - At most one req_ready bit high at any time, only for gnt_id.
//   - req_valid dropping during a grant is a protocol violation; behaviour is unchanged
//     (the byte is still sent and acked).
//   - No starvation: with all valid held, grants rotate 0, 1, ..., N-1, 0, ...
//   - A new req_valid arriving during a grant waits; it is never preempted.
//   - timer width is $clog2(ACK_TIMEOUT+1); it does not wrap within LOAD.
//  Throughput: one byte per transmitter frame plus about 1-2 baud periods of load latency.
// TESTING (bench uses the real transmitter, CLK_FRQ=50e6, BAUD_RATE=115200)
//  1 req_valid=4'b0001, data 0xA5 -> serial line shows start, 1,0,1,0,0,1,0,1, stop;
//    req_ready[0] pulses once, after tx_busy falls.
//  2 All 4 valid, bytes 0x10..0x13, re-asserted after each ack -> ack order 0,1,2,3,0,1;
//    line carries 0x10,0x11,0x12,0x13,...
//  3 Transmitter stubbed with tx_busy stuck 0, req 2 valid -> timeout_err after 2048 LOAD cycles;
//    no req_ready; next grant goes to req 3 when it is valid.
//  4 areset_n low mid-frame during grant 1 -> all outputs at reset values immediately;
//    after release, req 1 is re-arbitrated from index 0 and its byte is sent in full.
//  5 Requester 3 raises valid while req 0 is in WAIT_BUSY_LOW -> no preemption;
//    req 3 granted the cycle after req_ready[0].
//  6 Load timing across baud-tick phases (swept over 0..432 cycles) -> tx_busy asserted
//    within 2 baud periods every time; no timeout.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one 8N1 UART transmitter among NUM_REQ byte requesters.
// The load strobe keeps toggling until the transmitter reports busy. Each ack is issued after the byte has left the wire.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ACK_TIMEOUT = 2048
) (
  input  logic                       clk,
  input  logic                       areset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_data_loaded,
  output logic [7:0]                 tx_data_in,
  input  logic                       tx_busy,
  input  logic                       tx_done,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int TW  = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT} state_t;

  state_t               state_q, state_d;
  logic [IDW-1:0]       gnt_q, gnt_d;
  logic [IDW-1:0]       last_q, last_d;
  logic [7:0]           data_q, data_d;
  logic                 load_q, load_d;
  logic                 busy_q, busy_d;
  logic [NUM_REQ-1:0]   ready_q, ready_d;
  logic                 tout_q, tout_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 tx_busy_prev_q;

  logic [7:0]           req_byte [NUM_REQ];
  logic                 found;
  logic [IDW-1:0]       sel;
  logic [IDW-1:0]       idx;

  // The done flag is informational; completion is taken from the busy falling edge.
  logic unused_tx_done;
  assign unused_tx_done = tx_done;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
      assign req_byte[gi] = req_data[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDW'((int'(last_q) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    data_d  = data_q;
    load_d  = load_q;
    busy_d  = busy_q;
    ready_d = '0;
    tout_d  = 1'b0;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        // Skip the ack cycle so the just-served requester's stale valid is not re-granted.
        if (found && (ready_q == '0)) begin
          gnt_d   = sel;
          last_d  = sel;
          data_d  = req_byte[sel];
          busy_d  = 1'b1;
          timer_d = '0;
          load_d  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        timer_d = timer_q + 1'b1;
        if (tx_busy) begin
          load_d  = 1'b0;
          state_d = S_WAIT;
        end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
          load_d  = 1'b0;
          tout_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          load_d = ~load_q;
        end
      end
      S_WAIT: begin
        if (tx_busy_prev_q && !tx_busy) begin
          ready_d[gnt_q] = 1'b1;
          busy_d         = 1'b0;
          state_d        = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q        <= S_IDLE;
      gnt_q          <= '0;
      last_q         <= IDW'(NUM_REQ - 1);
      data_q         <= '0;
      load_q         <= 1'b0;
      busy_q         <= 1'b0;
      ready_q        <= '0;
      tout_q         <= 1'b0;
      timer_q        <= '0;
      tx_busy_prev_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      gnt_q          <= gnt_d;
      last_q         <= last_d;
      data_q         <= data_d;
      load_q         <= load_d;
      busy_q         <= busy_d;
      ready_q        <= ready_d;
      tout_q         <= tout_d;
      timer_q        <= timer_d;
      tx_busy_prev_q <= tx_busy;
    end
  end

  assign req_ready      = ready_q;
  assign tx_data_loaded = load_q;
  assign tx_data_in     = data_q;
  assign gnt_id         = gnt_q;
  assign busy           = busy_q;
  assign timeout_err    = tout_q;

endmodule
